// File: rtl/seq_counter_pkg.sv
// Shared definitions for the mode-selectable sequence counter:
// counting-mode encodings and the binary-to-Gray helper.
package seq_counter_pkg;

  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    MODE_UP       = 2'b00,
    MODE_DOWN     = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_GRAY     = 2'b11
  } mode_e;

  // Callers size the argument up to MAX_WIDTH and cast the result back down.
  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/bin2gray_enc.sv
// Purely combinational WIDTH-bit binary to Gray encoder.
module bin2gray_enc
  import seq_counter_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = WIDTH'(bin2gray(MAX_WIDTH'(bin)));

endmodule

// File: rtl/mode_seq_counter.sv
// Parametrised sequence counter with UP, DOWN, PINGPONG and GRAY modes,
// parallel load, direction flag and a registered one-cycle wrap pulse.
module mode_seq_counter
  import seq_counter_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MAX_VAL = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] countreg,
  output logic             dir,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

  if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("mode_seq_counter: WIDTH must be in 2..%0d", MAX_WIDTH);
  end

  if (MAX_VAL < 1 || longint'(MAX_VAL) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_max
    $error("mode_seq_counter: MAX_VAL must be in 1..2**WIDTH-1");
  end

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] gray_next;
  logic             dir_next;
  logic             wrap_next;

  // Load saturates to MAX_VAL so cnt can never leave 0..MAX_VAL.
  always_comb begin
    cnt_next  = cnt;
    dir_next  = dir;
    wrap_next = 1'b0;
    if (load) begin
      cnt_next = (load_val > MAXV) ? MAXV : load_val;
      dir_next = 1'b1;
    end else if (en) begin
      case (mode_e'(mode))
        MODE_UP, MODE_GRAY: begin
          dir_next = 1'b1;
          if (cnt == MAXV) begin
            cnt_next  = '0;
            wrap_next = 1'b1;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        MODE_DOWN: begin
          dir_next = 1'b0;
          if (cnt == '0) begin
            cnt_next  = MAXV;
            wrap_next = 1'b1;
          end else begin
            cnt_next = cnt - 1'b1;
          end
        end
        MODE_PINGPONG: begin
          if (dir && cnt == MAXV) begin
            cnt_next  = MAXV - 1'b1;
            dir_next  = 1'b0;
            wrap_next = 1'b1;
          end else if (!dir && cnt == '0) begin
            cnt_next  = WIDTH'(1);
            dir_next  = 1'b1;
            wrap_next = 1'b1;
          end else if (dir) begin
            cnt_next = cnt + 1'b1;
          end else begin
            cnt_next = cnt - 1'b1;
          end
        end
      endcase
    end
  end

  bin2gray_enc #(.WIDTH(WIDTH)) u_enc (
    .bin  (cnt_next),
    .gray (gray_next)
  );

  // countreg is encoded from cnt_next so it tracks the post-edge count directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      countreg <= '0;
      dir      <= 1'b1;
      wrap     <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      countreg <= (mode_e'(mode) == MODE_GRAY) ? gray_next : cnt_next;
      dir      <= dir_next;
      wrap     <= wrap_next;
    end
  end

endmodule

// File: tb/tb_mode_seq_counter.sv
// Directed self-checking bench for mode_seq_counter (WIDTH=3, MAX_VAL=5).
module tb_mode_seq_counter;
  import seq_counter_pkg::*;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [1:0]   mode = MODE_UP;
  logic [W-1:0] countreg;
  logic         dir;
  logic         wrap;

  int checks = 0;
  int errors = 0;

  mode_seq_counter #(.WIDTH(W), .MAX_VAL(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .mode     (mode),
    .countreg (countreg),
    .dir      (dir),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  // Drive one edge's worth of inputs, then sample 1 time unit after the edge.
  task automatic apply_stimulus(input logic r, input logic l, input logic e,
                                input logic [1:0] m, input logic [W-1:0] lv);
    rst      = r;
    load     = l;
    en       = e;
    mode     = m;
    load_val = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [W-1:0] c,
                              input logic d, input logic w);
    checks++;
    assert ({countreg, dir, wrap} === {c, d, w}) else begin
      errors++;
      $error("[TB] FAIL %s: observed countreg=%b dir=%b wrap=%b expected countreg=%b dir=%b wrap=%b",
             tag, countreg, dir, wrap, c, d, w);
    end
  endtask

  initial begin
    #2;

    apply_stimulus(1, 0, 0, MODE_UP, 0);   check_output("reset1", 0, 1, 0);
    apply_stimulus(1, 0, 0, MODE_UP, 0);   check_output("reset2", 0, 1, 0);

    apply_stimulus(0, 0, 1, MODE_UP, 0);   check_output("up1", 1, 1, 0);
    apply_stimulus(0, 0, 1, MODE_UP, 0);   check_output("up2", 2, 1, 0);
    apply_stimulus(0, 0, 1, MODE_UP, 0);   check_output("up3", 3, 1, 0);
    apply_stimulus(0, 0, 1, MODE_UP, 0);   check_output("up4", 4, 1, 0);
    apply_stimulus(0, 0, 1, MODE_UP, 0);   check_output("up5", 5, 1, 0);
    apply_stimulus(0, 0, 1, MODE_UP, 0);   check_output("up_wrap", 0, 1, 1);
    apply_stimulus(0, 0, 1, MODE_UP, 0);   check_output("up_after_wrap", 1, 1, 0);
    apply_stimulus(0, 0, 1, MODE_UP, 0);   check_output("up_2", 2, 1, 0);

    apply_stimulus(0, 1, 1, MODE_DOWN, 3); check_output("load3", 3, 1, 0);
    apply_stimulus(0, 0, 1, MODE_DOWN, 0); check_output("down2", 2, 0, 0);
    apply_stimulus(0, 0, 1, MODE_DOWN, 0); check_output("down1", 1, 0, 0);
    apply_stimulus(0, 0, 1, MODE_DOWN, 0); check_output("down0", 0, 0, 0);
    apply_stimulus(0, 0, 1, MODE_DOWN, 0); check_output("down_wrap", 5, 0, 1);
    apply_stimulus(0, 0, 1, MODE_DOWN, 0); check_output("down4", 4, 0, 0);
    apply_stimulus(0, 1, 0, MODE_DOWN, 7); check_output("load_sat", 5, 1, 0);

    apply_stimulus(1, 0, 0, MODE_PINGPONG, 0); check_output("pp_reset", 0, 1, 0);
    apply_stimulus(0, 0, 1, MODE_PINGPONG, 0); check_output("pp1", 1, 1, 0);
    apply_stimulus(0, 0, 1, MODE_PINGPONG, 0); check_output("pp2", 2, 1, 0);
    apply_stimulus(0, 0, 1, MODE_PINGPONG, 0); check_output("pp3", 3, 1, 0);
    apply_stimulus(0, 0, 1, MODE_PINGPONG, 0); check_output("pp4", 4, 1, 0);
    apply_stimulus(0, 0, 1, MODE_PINGPONG, 0); check_output("pp5", 5, 1, 0);
    apply_stimulus(0, 0, 1, MODE_PINGPONG, 0); check_output("pp_turn_top", 4, 0, 1);
    apply_stimulus(0, 0, 1, MODE_PINGPONG, 0); check_output("pp_d3", 3, 0, 0);
    apply_stimulus(0, 0, 1, MODE_PINGPONG, 0); check_output("pp_d2", 2, 0, 0);
    apply_stimulus(0, 0, 1, MODE_PINGPONG, 0); check_output("pp_d1", 1, 0, 0);
    apply_stimulus(0, 0, 1, MODE_PINGPONG, 0); check_output("pp_d0", 0, 0, 0);
    apply_stimulus(0, 0, 1, MODE_PINGPONG, 0); check_output("pp_turn_bot", 1, 1, 1);
    apply_stimulus(0, 0, 1, MODE_PINGPONG, 0); check_output("pp_u2", 2, 1, 0);

    apply_stimulus(1, 0, 0, MODE_GRAY, 0); check_output("gray_reset", 0, 1, 0);
    apply_stimulus(0, 0, 1, MODE_GRAY, 0); check_output("gray1", 3'b001, 1, 0);
    apply_stimulus(0, 0, 1, MODE_GRAY, 0); check_output("gray2", 3'b011, 1, 0);
    apply_stimulus(0, 0, 1, MODE_GRAY, 0); check_output("gray3", 3'b010, 1, 0);
    apply_stimulus(0, 0, 1, MODE_GRAY, 0); check_output("gray4", 3'b110, 1, 0);
    apply_stimulus(0, 0, 1, MODE_GRAY, 0); check_output("gray5", 3'b111, 1, 0);
    apply_stimulus(0, 0, 1, MODE_GRAY, 0); check_output("gray_wrap", 3'b000, 1, 1);
    apply_stimulus(0, 0, 1, MODE_GRAY, 0); check_output("gray1b", 3'b001, 1, 0);

    apply_stimulus(1, 0, 0, MODE_UP, 0);   check_output("en_reset", 0, 1, 0);
    apply_stimulus(0, 0, 1, MODE_UP, 0);   check_output("en_on1", 1, 1, 0);
    apply_stimulus(0, 0, 0, MODE_UP, 0);   check_output("en_hold1", 1, 1, 0);
    apply_stimulus(0, 0, 0, MODE_UP, 0);   check_output("en_hold2", 1, 1, 0);
    apply_stimulus(0, 0, 1, MODE_UP, 0);   check_output("en_on2", 2, 1, 0);
    apply_stimulus(0, 1, 0, MODE_UP, 5);   check_output("load5", 5, 1, 0);
    apply_stimulus(0, 0, 1, MODE_UP, 0);   check_output("hold_wrap", 0, 1, 1);
    apply_stimulus(0, 0, 0, MODE_UP, 0);   check_output("hold_clears_wrap", 0, 1, 0);

    apply_stimulus(0, 0, 1, MODE_UP, 0);   check_output("pre_rst_load", 1, 1, 0);
    apply_stimulus(1, 1, 1, MODE_UP, 4);   check_output("rst_over_load", 0, 1, 0);

    apply_stimulus(0, 1, 0, MODE_UP, 3);   check_output("load3b", 3'b011, 1, 0);
    apply_stimulus(0, 0, 0, MODE_GRAY, 0); check_output("reencode_gray", 3'b010, 1, 0);
    apply_stimulus(0, 0, 0, MODE_UP, 0);   check_output("reencode_bin", 3'b011, 1, 0);

    apply_stimulus(0, 0, 1, MODE_DOWN, 0);     check_output("mc_down", 2, 0, 0);
    apply_stimulus(0, 0, 1, MODE_PINGPONG, 0); check_output("mc_pp1", 1, 0, 0);
    apply_stimulus(0, 0, 1, MODE_PINGPONG, 0); check_output("mc_pp0", 0, 0, 0);
    apply_stimulus(0, 0, 1, MODE_PINGPONG, 0); check_output("mc_pp_turn", 1, 1, 1);
    apply_stimulus(0, 1, 0, MODE_PINGPONG, 4); check_output("mc_load_in_pp", 4, 1, 0);
    apply_stimulus(0, 0, 1, MODE_PINGPONG, 0); check_output("mc_pp5", 5, 1, 0);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
